// File: rtl/ccd_frame_capture.sv
// ccd_frame_capture
//   Upstream feeder for the imgproc stage. Samples raw 12-bit sensor data
//   qualified by frame/line valid and emits pixels with DVAL/X/Y qualifiers
//   plus a count of completed captured frames. Only whole frames are
//   captured; capture is armed by iSTART and stopped by iEND.
//
// Parameters
//   H_WIDTH   active pixels per line (X range 0..H_WIDTH-1)
//   V_HEIGHT  active lines per frame (Y range 0..V_HEIGHT-1)
//
// Ports
//   iCLK        pixel clock, rising edge
//   iRST        asynchronous active-low reset
//   iDATA       raw sensor pixel (12 bit)
//   iFVAL       sensor frame valid
//   iLVAL       sensor line valid
//   iSTART      1-cycle pulse, arm capture (also clears oOVF)
//   iEND        1-cycle pulse, stop after the current frame
//   iSW         test-pattern select (only with CCD_TEST_PATTERN_EN)
//   oDATA       captured pixel
//   oDVAL       pixel valid
//   oX_Cont     column of oDATA
//   oY_Cont     row of oDATA
//   oFrame_Cont completed captured frames (wraps)
//   oOVF        sticky: pixel or line beyond H_WIDTH/V_HEIGHT dropped
//
// Build option
//   CCD_TEST_PATTERN_EN: when defined and iSW=1, oDATA carries
//   {Y[5:0],X[5:0]} of the pixel instead of sensor data.

module ccd_frame_capture #(
  parameter int H_WIDTH  = 1280,
  parameter int V_HEIGHT = 960
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iDATA,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iSTART,
  input  logic        iEND,
  input  logic        iSW,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic [31:0] oFrame_Cont,
  output logic        oOVF
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t      state, state_next;
  logic        stop_pending, stop_pending_next;
  logic        frame_done;

  logic [11:0] m_data;
  logic        m_fval, m_lval, m_fval_d, m_lval_d;
  logic        fval_rise, fval_fall, lval_fall;

  logic [15:0] x_cnt, y_cnt, y_eff;
  logic        line_hit;
  logic        capturing, in_line, pix_ok, pix_drop;
  logic [11:0] pix_data;

  logic        q_dval;
  logic [11:0] q_data;
  logic [15:0] q_x, q_y;

  // Input register stage; the delayed copies give edge detection.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      m_data   <= '0;
      m_fval   <= 1'b0;
      m_lval   <= 1'b0;
      m_fval_d <= 1'b0;
      m_lval_d <= 1'b0;
    end else begin
      m_data   <= iDATA;
      m_fval   <= iFVAL;
      m_lval   <= iLVAL;
      m_fval_d <= m_fval;
      m_lval_d <= m_lval;
    end
  end

  assign fval_rise = m_fval & ~m_fval_d;
  assign fval_fall = ~m_fval & m_fval_d;
  assign lval_fall = ~m_lval & m_lval_d;

  // State register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
    end else begin
      state        <= state_next;
      stop_pending <= stop_pending_next;
    end
  end

  // Next-state logic. iEND always dominates iSTART; in CAPTURE a stop only
  // takes effect when the frame ends so frames are never truncated.
  always_comb begin
    state_next        = state;
    stop_pending_next = stop_pending;
    frame_done        = 1'b0;
    case (state)
      IDLE: begin
        if (iSTART && !iEND) state_next = ARMED;
      end
      ARMED: begin
        stop_pending_next = 1'b0;
        if (iEND)           state_next = IDLE;
        else if (fval_rise) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (iEND)        stop_pending_next = 1'b1;
        else if (iSTART) stop_pending_next = 1'b0;
        if (fval_fall) begin
          frame_done        = 1'b1;
          state_next        = stop_pending_next ? IDLE : ARMED;
          stop_pending_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The frame-start cycle already counts as capturing, and Y reads as 0
  // there, so a line starting together with FVAL is not lost.
  assign capturing = (state == CAPTURE) ||
                     ((state == ARMED) && fval_rise && !iEND);
  assign y_eff     = fval_rise ? 16'd0 : y_cnt;
  assign in_line   = capturing & m_fval & m_lval;
  assign pix_ok    = in_line && (x_cnt < 16'(H_WIDTH)) && (y_eff < 16'(V_HEIGHT));
  assign pix_drop  = in_line & ~pix_ok;

`ifdef CCD_TEST_PATTERN_EN
  assign pix_data = iSW ? {y_eff[5:0], x_cnt[5:0]} : m_data;
`else
  // iSW has no effect in this build; both arms select the sensor data.
  assign pix_data = iSW ? m_data : m_data;
`endif

  // Column/row counters. X saturates at H_WIDTH so extra pixels are
  // dropped; Y advances only for lines that produced at least one pixel.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      line_hit <= 1'b0;
    end else begin
      if (lval_fall)   x_cnt <= '0;
      else if (pix_ok) x_cnt <= x_cnt + 16'd1;

      if (fval_rise)                  y_cnt <= '0;
      else if (lval_fall && line_hit) y_cnt <= y_cnt + 16'd1;

      if (lval_fall)   line_hit <= 1'b0;
      else if (pix_ok) line_hit <= 1'b1;
    end
  end

  // Frame counter and sticky overflow flag.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oFrame_Cont <= '0;
      oOVF        <= 1'b0;
    end else begin
      if (frame_done) oFrame_Cont <= oFrame_Cont + 32'd1;
      if (pix_drop)   oOVF <= 1'b1;
      else if (iSTART) oOVF <= 1'b0;
    end
  end

  // Two output stages give the two-edge latency from the input register;
  // data, X and Y only update on valid pixels so they hold otherwise.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      q_dval  <= 1'b0;
      q_data  <= '0;
      q_x     <= '0;
      q_y     <= '0;
      oDVAL   <= 1'b0;
      oDATA   <= '0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else begin
      q_dval <= pix_ok;
      if (pix_ok) begin
        q_data <= pix_data;
        q_x    <= x_cnt;
        q_y    <= y_eff;
      end
      oDVAL <= q_dval;
      if (q_dval) begin
        oDATA   <= q_data;
        oX_Cont <= q_x;
        oY_Cont <= q_y;
      end
    end
  end

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Testbench for ccd_frame_capture with a 4x4 active window.
module tb_ccd_frame_capture;

  localparam int H = 4;
  localparam int V = 4;

  logic        iCLK, iRST;
  logic [11:0] iDATA;
  logic        iFVAL, iLVAL, iSTART, iEND, iSW;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [15:0] oX_Cont, oY_Cont;
  logic [31:0] oFrame_Cont;
  logic        oOVF;

  int checks   = 0;
  int failures = 0;

  logic [43:0] cap_q[$];

  ccd_frame_capture #(.H_WIDTH(H), .V_HEIGHT(V)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
    .iSTART(iSTART), .iEND(iEND), .iSW(iSW), .oDATA(oDATA), .oDVAL(oDVAL),
    .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont), .oOVF(oOVF)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Record every valid output pixel as {data, x, y}.
  always @(posedge iCLK) begin
    #1;
    if (oDVAL === 1'b1) cap_q.push_back({oDATA, oX_Cont, oY_Cont});
  end

  function automatic logic [11:0] exp_pix(input logic [11:0] base, input int l, input int p);
`ifdef CCD_TEST_PATTERN_EN
    if (iSW) return {6'(l), 6'(p)};
`endif
    return base + 12'(l * 16 + p);
  endfunction

  task automatic pulse_start();
    @(negedge iCLK); iSTART = 1'b1;
    @(negedge iCLK); iSTART = 1'b0;
  endtask

  // One frame: FVAL leads LVAL by two cycles, two idle cycles between lines.
  task automatic drive_frame(input int n_lines, input int n_pix, input logic [11:0] base,
                             input int start_line, input int end_line);
    @(negedge iCLK); iFVAL = 1'b1;
    repeat (2) @(negedge iCLK);
    for (int l = 0; l < n_lines; l++) begin
      for (int p = 0; p < n_pix; p++) begin
        iLVAL  = 1'b1;
        iDATA  = base + 12'(l * 16 + p);
        iSTART = (p == 0) && (l == start_line);
        iEND   = (p == 0) && (l == end_line);
        @(negedge iCLK);
      end
      iSTART = 1'b0; iEND = 1'b0; iLVAL = 1'b0; iDATA = '0;
      repeat (2) @(negedge iCLK);
    end
    iFVAL = 1'b0;
    repeat (4) @(negedge iCLK);
  endtask

  task automatic test_reset();
    iRST = 1'b0; iDATA = '0; iFVAL = 0; iLVAL = 0; iSTART = 0; iEND = 0; iSW = 0;
    #12;
    checks++; if (oDVAL !== 1'b0) begin failures++; $display("[TB] FAIL reset_dval got=%0h exp=0", oDVAL); end
    checks++; if (oDATA !== 12'h0) begin failures++; $display("[TB] FAIL reset_data got=%0h exp=0", oDATA); end
    checks++; if (oX_Cont !== 16'h0 || oY_Cont !== 16'h0) begin failures++; $display("[TB] FAIL reset_xy got=%0h/%0h exp=0/0", oX_Cont, oY_Cont); end
    checks++; if (oFrame_Cont !== 32'h0) begin failures++; $display("[TB] FAIL reset_frames got=%0h exp=0", oFrame_Cont); end
    checks++; if (oOVF !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%0h exp=0", oOVF); end
    @(negedge iCLK); iRST = 1'b1;
    @(negedge iCLK);
  endtask

  task automatic test_no_start();
    cap_q.delete();
    drive_frame(4, 4, 12'h100, -1, -1);
    checks++; if (cap_q.size() != 0) begin failures++; $display("[TB] FAIL nostart_pixels got=%0d exp=0", cap_q.size()); end
    checks++; if (oFrame_Cont !== 32'd0) begin failures++; $display("[TB] FAIL nostart_frames got=%0d exp=0", oFrame_Cont); end
  endtask

  task automatic test_midframe_start();
    logic [43:0] exp;
    cap_q.delete();
    drive_frame(4, 4, 12'h100, 1, -1);
    checks++; if (cap_q.size() != 0) begin failures++; $display("[TB] FAIL partial_pixels got=%0d exp=0", cap_q.size()); end
    drive_frame(4, 4, 12'h200, -1, -1);
    drive_frame(4, 4, 12'h300, -1, -1);
    checks++; if (cap_q.size() != 32) begin failures++; $display("[TB] FAIL two_frames_pixels got=%0d exp=32", cap_q.size()); end
    checks++; if (oFrame_Cont !== 32'd2) begin failures++; $display("[TB] FAIL two_frames_count got=%0d exp=2", oFrame_Cont); end
    for (int i = 0; i < 32 && i < cap_q.size(); i++) begin
      exp = {exp_pix((i < 16) ? 12'h200 : 12'h300, (i % 16) / 4, i % 4), 16'(i % 4), 16'((i % 16) / 4)};
      checks++;
      if (cap_q[i] !== exp) begin
        failures++; $display("[TB] FAIL frame_pixel[%0d] got=%h exp=%h", i, cap_q[i], exp);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge iCLK); iFVAL = 1'b1;
    repeat (2) @(negedge iCLK);
    iLVAL = 1'b1; iDATA = 12'hABC;
    @(posedge iCLK);
    @(negedge iCLK); iLVAL = 1'b0; iDATA = 12'h000;
    @(posedge iCLK); #1;
    checks++; if (oDVAL !== 1'b0) begin failures++; $display("[TB] FAIL latency_early_dval got=%0h exp=0", oDVAL); end
    @(posedge iCLK); #1;
    checks++; if (oDVAL !== 1'b1 || oDATA !== 12'hABC) begin failures++; $display("[TB] FAIL latency_pixel got=%0h/%h exp=1/abc", oDVAL, oDATA); end
    checks++; if (oX_Cont !== 16'd0 || oY_Cont !== 16'd0) begin failures++; $display("[TB] FAIL latency_xy got=%0d/%0d exp=0/0", oX_Cont, oY_Cont); end
    @(posedge iCLK); #1;
    checks++; if (oDVAL !== 1'b0 || oDATA !== 12'hABC) begin failures++; $display("[TB] FAIL latency_hold got=%0h/%h exp=0/abc", oDVAL, oDATA); end
    repeat (2) @(negedge iCLK);
    iFVAL = 1'b0;
    repeat (4) @(negedge iCLK);
    checks++; if (oFrame_Cont !== 32'd3) begin failures++; $display("[TB] FAIL latency_frames got=%0d exp=3", oFrame_Cont); end
  endtask

  task automatic test_overflow();
    logic [43:0] exp;
    iSW = 1'b1;
    cap_q.delete();
    drive_frame(5, 6, 12'h400, -1, -1);
    checks++; if (cap_q.size() != 16) begin failures++; $display("[TB] FAIL ovf_pixels got=%0d exp=16", cap_q.size()); end
    for (int i = 0; i < 16 && i < cap_q.size(); i++) begin
      exp = {exp_pix(12'h400, i / 4, i % 4), 16'(i % 4), 16'(i / 4)};
      checks++;
      if (cap_q[i] !== exp) begin
        failures++; $display("[TB] FAIL ovf_pixel[%0d] got=%h exp=%h", i, cap_q[i], exp);
      end
    end
    checks++; if (oX_Cont !== 16'd3 || oY_Cont !== 16'd3) begin failures++; $display("[TB] FAIL ovf_xy_hold got=%0d/%0d exp=3/3", oX_Cont, oY_Cont); end
    checks++; if (oFrame_Cont !== 32'd4) begin failures++; $display("[TB] FAIL ovf_frames got=%0d exp=4", oFrame_Cont); end
    iSW = 1'b0;
    repeat (3) @(negedge iCLK);
    checks++; if (oOVF !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%0h exp=1", oOVF); end
    pulse_start();
    checks++; if (oOVF !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%0h exp=0", oOVF); end
  endtask

  task automatic test_end();
    cap_q.delete();
    drive_frame(4, 4, 12'h500, -1, 1);
    checks++; if (cap_q.size() != 16) begin failures++; $display("[TB] FAIL end_pixels got=%0d exp=16", cap_q.size()); end
    checks++; if (oFrame_Cont !== 32'd5) begin failures++; $display("[TB] FAIL end_frames got=%0d exp=5", oFrame_Cont); end
    cap_q.delete();
    drive_frame(4, 4, 12'h600, -1, -1);
    checks++; if (cap_q.size() != 0) begin failures++; $display("[TB] FAIL after_end_pixels got=%0d exp=0", cap_q.size()); end
    checks++; if (oFrame_Cont !== 32'd5) begin failures++; $display("[TB] FAIL after_end_frames got=%0d exp=5", oFrame_Cont); end
  endtask

  task automatic test_start_end();
    @(negedge iCLK); iSTART = 1'b1; iEND = 1'b1;
    @(negedge iCLK); iSTART = 1'b0; iEND = 1'b0;
    cap_q.delete();
    drive_frame(4, 4, 12'h600, -1, -1);
    checks++; if (cap_q.size() != 0) begin failures++; $display("[TB] FAIL start_end_same_pixels got=%0d exp=0", cap_q.size()); end
    pulse_start();
    @(negedge iCLK); iEND = 1'b1;
    @(negedge iCLK); iEND = 1'b0;
    drive_frame(4, 4, 12'h600, -1, -1);
    checks++; if (cap_q.size() != 0) begin failures++; $display("[TB] FAIL armed_end_pixels got=%0d exp=0", cap_q.size()); end
    checks++; if (oFrame_Cont !== 32'd5) begin failures++; $display("[TB] FAIL start_end_frames got=%0d exp=5", oFrame_Cont); end
  endtask

  task automatic test_lval_only();
    pulse_start();
    cap_q.delete();
    for (int k = 0; k < 2; k++) begin
      iLVAL = 1'b1; iDATA = 12'h0EE;
      repeat (3) @(negedge iCLK);
      iLVAL = 1'b0;
      repeat (2) @(negedge iCLK);
    end
    repeat (3) @(negedge iCLK);
    checks++; if (cap_q.size() != 0) begin failures++; $display("[TB] FAIL lval_only_pixels got=%0d exp=0", cap_q.size()); end
    drive_frame(4, 4, 12'h700, -1, -1);
    checks++; if (cap_q.size() != 16) begin failures++; $display("[TB] FAIL lval_frame_pixels got=%0d exp=16", cap_q.size()); end
    if (cap_q.size() > 0) begin
      checks++;
      if (cap_q[0] !== {12'h700, 16'd0, 16'd0}) begin failures++; $display("[TB] FAIL lval_first_pixel got=%h exp=%h", cap_q[0], {12'h700, 16'd0, 16'd0}); end
      checks++;
      if (cap_q[cap_q.size()-1] !== {12'h733, 16'd3, 16'd3}) begin failures++; $display("[TB] FAIL lval_last_pixel got=%h exp=%h", cap_q[cap_q.size()-1], {12'h733, 16'd3, 16'd3}); end
    end
    checks++; if (oFrame_Cont !== 32'd6) begin failures++; $display("[TB] FAIL lval_frames got=%0d exp=6", oFrame_Cont); end
  endtask

  task automatic test_async_reset();
    @(negedge iCLK); iFVAL = 1'b1;
    repeat (2) @(negedge iCLK);
    iLVAL = 1'b1; iDATA = 12'h7AA;
    repeat (3) @(negedge iCLK);
    #2 iRST = 1'b0;
    #1;
    checks++; if (oDVAL !== 1'b0 || oDATA !== 12'h0) begin failures++; $display("[TB] FAIL async_rst_out got=%0h/%h exp=0/0", oDVAL, oDATA); end
    checks++; if (oFrame_Cont !== 32'd0 || oX_Cont !== 16'd0) begin failures++; $display("[TB] FAIL async_rst_cnt got=%0d/%0d exp=0/0", oFrame_Cont, oX_Cont); end
    @(negedge iCLK); iRST = 1'b1;
    repeat (2) @(negedge iCLK);
    iLVAL = 1'b0;
    repeat (2) @(negedge iCLK);
    iFVAL = 1'b0;
    repeat (3) @(negedge iCLK);
    cap_q.delete();
    drive_frame(4, 4, 12'h800, -1, -1);
    checks++; if (cap_q.size() != 0) begin failures++; $display("[TB] FAIL post_rst_nostart got=%0d exp=0", cap_q.size()); end
    pulse_start();
    drive_frame(4, 4, 12'h800, -1, -1);
    checks++; if (cap_q.size() != 16) begin failures++; $display("[TB] FAIL post_rst_capture got=%0d exp=16", cap_q.size()); end
    checks++; if (oFrame_Cont !== 32'd1) begin failures++; $display("[TB] FAIL post_rst_frames got=%0d exp=1", oFrame_Cont); end
  endtask

  initial begin
    test_reset();
    test_no_start();
    test_midframe_start();
    test_latency();
    test_overflow();
    test_end();
    test_start_end();
    test_lval_only();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
